// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// Frame states and parity encodings used by the top and the sampler.
package uart_rx_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter plus 3-sample majority vote around mid-bit.
// The start-detect edge is edge 0 of the start bit.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] prescale,
    input  logic       rx_in,
    output logic       sampled_bit,
    output logic       bit_done
);

    logic [5:0] edge_cnt;
    logic [5:0] half;
    logic [2:0] smp;

    assign half     = {1'b0, prescale[5:1]};
    assign bit_done = en && (edge_cnt == prescale - 6'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= 6'd0;
        end else if (!en || bit_done) begin
            edge_cnt <= 6'd0;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp         <= 3'b000;
            sampled_bit <= 1'b0;
        end else begin
            if (edge_cnt == half - 6'd1) smp[0] <= rx_in;
            if (edge_cnt == half)        smp[1] <= rx_in;
            if (edge_cnt == half + 6'd1) smp[2] <= rx_in;
            if (edge_cnt == half + 6'd2) begin
                sampled_bit <= (smp[0] & smp[1]) |
                               (smp[0] & smp[2]) |
                               (smp[1] & smp[2]);
            end
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: frame FSM, data shift register, parity/stop checks.
// Config inputs are latched at start detection for the whole frame.
module uart_rx_top
    import uart_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PAR_TYP,
    input  logic                  PAR_EN,
    input  logic [5:0]            Prescale,
    input  logic                  RX_IN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid
);

    state_t                state, nxt;
    logic [3:0]            bit_cnt;
    logic [2:0]            idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q, par_typ_q, par_err;
    logic [5:0]            presc_q;
    logic                  start_det, en;
    logic                  sampled_bit, bit_done;
    logic                  shift_en, par_chk, frame_ok;

    assign start_det = (state == IDLE) && !RX_IN;
    assign en        = (state != IDLE) || start_det;
    // bit_cnt 0 is the start bit, so data bit n sits at bit_cnt n+1
    assign idx       = 3'(bit_cnt - 4'd1);

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .prescale   (presc_q),
        .rx_in      (RX_IN),
        .sampled_bit(sampled_bit),
        .bit_done   (bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (!RX_IN) nxt = START;
            START:   if (bit_done) nxt = sampled_bit ? IDLE : DATA;
            DATA:    if (bit_done && bit_cnt == 4'd8)
                         nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_done) nxt = STOP;
            STOP:    if (bit_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_en = (state == DATA) && bit_done;
        par_chk  = (state == PARITY) && bit_done;
        frame_ok = (state == STOP) && bit_done && sampled_bit && !par_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= 4'd0;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            presc_q    <= 6'd0;
            par_err    <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
        end else begin
            if (start_det) begin
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                presc_q    <= Prescale;
                bit_cnt    <= 4'd0;
                par_err    <= 1'b0;
                data_valid <= 1'b0;
            end else if (bit_done) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (shift_en) shift_reg[idx] <= sampled_bit;
            if (par_chk) begin
                par_err <= sampled_bit !=
                           ((par_typ_q == PAR_ODD) ? ~^shift_reg : ^shift_reg);
            end
            if (frame_ok) begin
                P_DATA     <= shift_reg;
                data_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: good frames, bad parity/stop,
// start glitch and reset mid-frame.
module tb_uart_rx_top;

    logic       clk;
    logic       rst;
    logic       par_typ;
    logic       par_en;
    logic [5:0] prescale;
    logic       rx_in;
    logic [7:0] p_data;
    logic       data_valid;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_top dut (
        .clk       (clk),
        .rst       (rst),
        .PAR_TYP   (par_typ),
        .PAR_EN    (par_en),
        .Prescale  (prescale),
        .RX_IN     (rx_in),
        .P_DATA    (p_data),
        .data_valid(data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (prescale) @(posedge clk);
        #1;
    endtask

    // data_valid must still be low one clk before the last stop-bit edge
    task automatic send_frame(input string tag, input logic [7:0] d,
                              input logic has_par, input logic par_bit,
                              input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(par_bit);
        rx_in = stop;
        repeat (prescale - 1) @(posedge clk);
        #1;
        chk({tag, "_early"}, {7'b0, data_valid}, 8'h00);
        @(posedge clk);
        #1;
        rx_in = 1'b1;
    endtask

    task automatic cfg(input logic en, input logic typ, input logic [5:0] p);
        par_en   = en;
        par_typ  = typ;
        prescale = p;
    endtask

    initial begin
        rst   = 1'b1;
        rx_in = 1'b1;
        cfg(1'b0, 1'b0, 6'd8);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pdata", p_data, 8'h00);
        chk("rst_dv", {7'b0, data_valid}, 8'h00);
        rst = 1'b0;
        idle(3);

        send_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b1);
        chk("a5_dv", {7'b0, data_valid}, 8'h01);
        chk("a5_pdata", p_data, 8'hA5);
        idle(5);
        chk("a5_hold_dv", {7'b0, data_valid}, 8'h01);

        rx_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_pdata", p_data, 8'h00);
        chk("midrst_dv", {7'b0, data_valid}, 8'h00);
        rst = 1'b0;
        idle(4);

        cfg(1'b1, 1'b0, 6'd16);
        send_frame("3c", 8'h3C, 1'b1, 1'b0, 1'b1);
        chk("3c_dv", {7'b0, data_valid}, 8'h01);
        chk("3c_pdata", p_data, 8'h3C);
        idle(4);

        cfg(1'b1, 1'b1, 6'd32);
        send_frame("81", 8'h81, 1'b1, 1'b1, 1'b1);
        chk("81_dv", {7'b0, data_valid}, 8'h01);
        chk("81_pdata", p_data, 8'h81);
        idle(4);

        cfg(1'b1, 1'b0, 6'd8);
        send_frame("badpar", 8'h5A, 1'b1, 1'b1, 1'b1);
        chk("badpar_dv", {7'b0, data_valid}, 8'h00);
        chk("badpar_pdata", p_data, 8'h81);
        idle(4);

        cfg(1'b0, 1'b0, 6'd8);
        send_frame("badstop", 8'h77, 1'b0, 1'b0, 1'b0);
        chk("badstop_dv", {7'b0, data_valid}, 8'h00);
        chk("badstop_pdata", p_data, 8'h81);
        idle(4);

        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(12);
        chk("glitch_dv", {7'b0, data_valid}, 8'h00);
        chk("glitch_pdata", p_data, 8'h81);

        send_frame("ff", 8'hFF, 1'b0, 1'b0, 1'b1);
        chk("ff_dv", {7'b0, data_valid}, 8'h01);
        chk("ff_pdata", p_data, 8'hFF);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
